// File: rtl/complement_stream_st.sv
// Streaming DNA base complementer with optional per-beat lane reversal and a 2-entry skid buffer.
// Define COMPLEMENT_STREAM_IUPAC_EN to also complement IUPAC ambiguity codes.
module complement_stream_st #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned COUNT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_last,
  input  logic                 in_rev,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_last,
  input  logic                 stat_clear,
  output logic [COUNT_W-1:0]   base_count,
  output logic [COUNT_W-1:0]   invalid_count
);

  localparam int unsigned DATA_W = 8 * LANES;
  localparam int unsigned INC_W  = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   skid_data_q;
  logic                skid_last_q;
  logic [DATA_W-1:0]   beat_c;
  logic [INC_W-1:0]    inv_cnt_c;
  logic                accept_c;
  logic                load_main_in_c;
  logic                load_main_skid_c;
  logic                load_skid_c;
  logic [COUNT_W:0]    base_sum_c;
  logic [COUNT_W:0]    inv_sum_c;

  // Returns {invalid, complemented byte}; unknown bytes pass through flagged invalid.
  function automatic logic [8:0] comp_byte(input logic [7:0] b);
    logic [8:0] r;
    r = {1'b0, b};
    case (b)
      "A": r[7:0] = "T";
      "T": r[7:0] = "A";
      "C": r[7:0] = "G";
      "G": r[7:0] = "C";
      "a": r[7:0] = "t";
      "t": r[7:0] = "a";
      "c": r[7:0] = "g";
      "g": r[7:0] = "c";
      "N", "n": r[7:0] = b;
`ifdef COMPLEMENT_STREAM_IUPAC_EN
      "R": r[7:0] = "Y";
      "Y": r[7:0] = "R";
      "K": r[7:0] = "M";
      "M": r[7:0] = "K";
      "B": r[7:0] = "V";
      "V": r[7:0] = "B";
      "D": r[7:0] = "H";
      "H": r[7:0] = "D";
      "r": r[7:0] = "y";
      "y": r[7:0] = "r";
      "k": r[7:0] = "m";
      "m": r[7:0] = "k";
      "b": r[7:0] = "v";
      "v": r[7:0] = "b";
      "d": r[7:0] = "h";
      "h": r[7:0] = "d";
      "S", "W", "s", "w": r[7:0] = b;
`endif
      default: r = {1'b1, b};
    endcase
    return r;
  endfunction

  // Per-lane complement with optional lane reversal, plus invalid-lane tally.
  always_comb begin
    logic [7:0] src;
    logic [8:0] res;
    beat_c    = '0;
    inv_cnt_c = '0;
    src       = '0;
    res       = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      src = in_rev ? in_data[8*(int'(LANES)-1-k) +: 8] : in_data[8*k +: 8];
      res = comp_byte(src);
      beat_c[8*k +: 8] = res[7:0];
      inv_cnt_c = inv_cnt_c + INC_W'(res[8]);
    end
  end

  assign accept_c = in_valid & in_ready;

  // Next-state and storage-steering decode.
  always_comb begin
    state_d          = state_q;
    load_main_in_c   = 1'b0;
    load_main_skid_c = 1'b0;
    load_skid_c      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          load_main_in_c = 1'b1;
          state_d        = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (accept_c) load_main_in_c = 1'b1;
          else          state_d        = ST_EMPTY;
        end else if (accept_c) begin
          load_skid_c = 1'b1;
          state_d     = ST_SKID;
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          load_main_skid_c = 1'b1;
          state_d          = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign base_sum_c = {1'b0, base_count} + (COUNT_W+1)'(LANES);
  assign inv_sum_c  = {1'b0, invalid_count} + (COUNT_W+1)'(inv_cnt_c);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_EMPTY;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      skid_data_q   <= '0;
      skid_last_q   <= 1'b0;
      base_count    <= '0;
      invalid_count <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != ST_SKID);
      out_valid <= (state_d != ST_EMPTY);
      if (load_main_in_c) begin
        out_data <= beat_c;
        out_last <= in_last;
      end else if (load_main_skid_c) begin
        out_data <= skid_data_q;
        out_last <= skid_last_q;
      end
      if (load_skid_c) begin
        skid_data_q <= beat_c;
        skid_last_q <= in_last;
      end
      // Clear wins over a same-cycle accept; counters saturate instead of wrapping.
      if (stat_clear) begin
        base_count    <= '0;
        invalid_count <= '0;
      end else if (accept_c) begin
        base_count    <= base_sum_c[COUNT_W] ? '1 : base_sum_c[COUNT_W-1:0];
        invalid_count <= inv_sum_c[COUNT_W]  ? '1 : inv_sum_c[COUNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_complement_stream_st.sv
// Randomized bench for complement_stream_st against a queue-based reference model.
module tb_complement_stream_st;

  localparam int unsigned LANES   = 4;
  localparam int unsigned COUNT_W = 32;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [8*LANES-1:0]  in_data = '0;
  logic                in_last = 1'b0;
  logic                in_rev = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [8*LANES-1:0]  out_data;
  logic                out_last;
  logic                stat_clear = 1'b0;
  logic [COUNT_W-1:0]  base_count;
  logic [COUNT_W-1:0]  invalid_count;

  complement_stream_st #(.LANES(LANES), .COUNT_W(COUNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_rev(in_rev),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .stat_clear(stat_clear),
    .base_count(base_count), .invalid_count(invalid_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [8*LANES-1:0] d;
    logic               l;
  } beat_t;

  beat_t           q[$];
  longint unsigned m_base;
  longint unsigned m_inv;
  int              n_checks;
  int              n_fail;
  localparam longint unsigned CNT_MAX = (64'd1 << COUNT_W) - 1;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_comp(input logic [7:0] b, output bit ok);
    string f = "ACGTacgtNn";
    string t = "TGCAtgcaNn";
`ifdef COMPLEMENT_STREAM_IUPAC_EN
    f = {f, "RYKMBVDHSWrykmbvdhsw"};
    t = {t, "YRMKVBHDSWyrmkvbhdsw"};
`endif
    for (int i = 0; i < f.len(); i++)
      if (f[i] == b) begin
        ok = 1'b1;
        return t[i];
      end
    ok = 1'b0;
    return b;
  endfunction

  task automatic ref_beat(input logic [8*LANES-1:0] d, input bit rev,
                          output logic [8*LANES-1:0] o, output int ninv);
    bit ok;
    ninv = 0;
    o = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      o[8*k +: 8] = ref_comp(rev ? d[8*(int'(LANES)-1-k) +: 8] : d[8*k +: 8], ok);
      if (!ok) ninv++;
    end
  endtask

  // One cycle: check outputs against the model, drive inputs, advance the model past the edge.
  task automatic step(input bit v, input logic [8*LANES-1:0] d, input bit l, input bit r,
                      input bit ordy, input bit clr);
    beat_t b;
    int    ninv;
    bit    acc;
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      check("out_data", 64'(out_data), 64'(q[0].d));
      check("out_last", 64'(out_last), 64'(q[0].l));
    end
    check("base_count", 64'(base_count), m_base);
    check("invalid_count", 64'(invalid_count), m_inv);
    in_valid = v; in_data = d; in_last = l; in_rev = r; out_ready = ordy; stat_clear = clr;
    acc = v && (q.size() < 2);
    if (q.size() > 0 && ordy) void'(q.pop_front());
    if (acc) begin
      ref_beat(d, r, b.d, ninv);
      b.l = l;
      q.push_back(b);
    end
    if (clr) begin
      m_base = 0;
      m_inv  = 0;
    end else if (acc) begin
      m_base = (m_base + LANES > CNT_MAX) ? CNT_MAX : m_base + LANES;
      m_inv  = (m_inv + 64'(ninv) > CNT_MAX) ? CNT_MAX : m_inv + 64'(ninv);
    end
    @(negedge clock);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, '0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; stat_clear = 1'b0;
    q.delete();
    m_base = 0;
    m_inv  = 0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_base_count", 64'(base_count), 64'd0);
    check("rst_invalid_count", 64'(invalid_count), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  function automatic logic [7:0] rand_base();
    string alpha = "ACGTacgtNnRYKMBVDHSWrykmbvdhswX-";
    if ($urandom_range(0, 15) == 0) return 8'($urandom);
    return alpha[$urandom_range(0, alpha.len() - 1)];
  endfunction

  logic [8*LANES-1:0] lit_in;
  logic [8*LANES-1:0] lit_out;
  logic [8*LANES-1:0] rd;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_base   = 0;
    m_inv    = 0;
    @(negedge clock);
    do_reset();

    // Single ACGT beat (lane0='A'), forward then reversed.
    lit_in  = "TGCA";
    lit_out = "ACGT";
    step(1'b1, lit_in, 1'b0, 1'b0, 1'b1, 1'b0);
    check("acgt_fwd_data", 64'(out_data), 64'(lit_out));
    idle(1'b1);
    check("acgt_one_cycle", 64'(out_valid), 64'd0);
    check("acgt_base", 64'(base_count), 64'd4);
    check("acgt_invalid", 64'(invalid_count), 64'd0);
    lit_out = "TGCA";
    step(1'b1, lit_in, 1'b0, 1'b1, 1'b1, 1'b0);
    check("acgt_rev_data", 64'(out_data), 64'(lit_out));
    idle(1'b1);

    // Continuous 16 beats with last on the 16th.
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < int'(LANES); k++) rd[8*k +: 8] = rand_base();
      step(1'b1, rd, i == 15, 1'(i % 3 == 0), 1'b1, 1'b0);
    end
    check("burst_last", 64'(out_last), 64'd1);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: offer 3 beats with out_ready low.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h41414141 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h41414143, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Mixed/invalid bytes: "AXgr" (lane0='A').
    do_reset();
    lit_in = "rgXA";
`ifdef COMPLEMENT_STREAM_IUPAC_EN
    lit_out = "ycXT";
`else
    lit_out = "rcXT";
`endif
    step(1'b1, lit_in, 1'b0, 1'b0, 1'b1, 1'b0);
    check("axgr_data", 64'(out_data), 64'(lit_out));
`ifdef COMPLEMENT_STREAM_IUPAC_EN
    check("axgr_invalid", 64'(invalid_count), 64'd1);
`else
    check("axgr_invalid", 64'(invalid_count), 64'd2);
`endif
    idle(1'b1);

    // stat_clear on an accept cycle at base_count=12.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h47474747, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_clear_base", 64'(base_count), 64'd12);
    step(1'b1, 32'h58585858, 1'b0, 1'b0, 1'b1, 1'b1);
    check("clear_base", 64'(base_count), 64'd0);
    check("clear_invalid", 64'(invalid_count), 64'd0);
    idle(1'b1);

    // Reset while in SKID.
    step(1'b1, 32'h41434754, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h54474341, 1'b0, 1'b0, 1'b0, 1'b0);
    check("skid_ready_low", 64'(in_ready), 64'd0);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < int'(LANES); k++) rd[8*k +: 8] = rand_base();
      step(1'($urandom_range(0, 3) != 0), rd, 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/complement_stream_st.md
Name: complement_stream_st

Overview:
- Streaming DNA base complementer; LANES ASCII bases per beat, valid/ready on both sides, full throughput (1 beat/cycle) via 2-entry skid buffer.
- Optional per-beat lane reversal yields reverse-complement of the beat.
- Sits in the sequence pipeline between reader and downstream matcher; exports accepted-base and invalid-base counters to the CSR block.

Parameters:
- LANES, 4, bases per beat; data width 8*LANES; lane k = bits [8k+7:8k].
- COUNT_W, 32, width of both statistics counters.

Ports:
- clock  in  1  single clock, all logic posedge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat; registered.
- in_data  in  8*LANES  input bases.
- in_last  in  1  last beat of sequence; passed through with the beat.
- in_rev  in  1  reverse lane order for this beat; sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8*LANES  complemented bases.
- out_last  out  1  in_last of this beat.
- stat_clear  in  1  synchronous clear of counters.
- base_count  out  COUNT_W  bases accepted since reset/clear.
- invalid_count  out  COUNT_W  accepted bases not in complement table.

Behaviour:
- Reset (reset low, async): in_ready=1, out_valid=0, out_data=0, out_last=0, both counters=0, skid empty. Reset mid-transfer discards all held beats.
- Accept on in_valid & in_ready; transfer on out_valid & out_ready.
- Complement is combinational on in_data; the result is registered. Latency: an accepted beat appears on out_* the next cycle.
- Table: A<->T, C<->G, a<->t, c<->g, N->N, n->n. Case is preserved.
- Any other byte passes unchanged and is counted as invalid.
- in_rev=1: out lane k = complement(in lane LANES-1-k). in_rev=0: lane order kept.
- Storage: main register (drives out_*) plus skid register.
- State EMPTY (out_valid=0): accept -> main, go FULL.
- State FULL:
  - out_ready and no accept -> EMPTY.
  - out_ready and accept -> main reloads, stays FULL (no bubble).
  - no out_ready and accept -> beat goes to skid, go SKID.
- State SKID:
  - in_ready=0 (deasserted the cycle after the skid fills).
  - on out_ready: skid moves to main -> FULL, in_ready=1 next cycle.
- in_ready = !skid_full, registered. No beat is lost or duplicated.
- out_data and out_last are stable while out_valid & !out_ready.
- Counters:
  - per accepted beat: base_count += LANES; invalid_count += number of invalid lanes.
  - both saturate at 2^COUNT_W-1, never wrap.
  - stat_clear loads 0 and wins over a simultaneous accept; that beat is not counted.

Optional Feature:
- Macro: COMPLEMENT_STREAM_IUPAC_EN.
- Defined: IUPAC ambiguity codes (both cases) are complemented and counted valid: R<->Y, K<->M, B<->V, D<->H; S, W, N map to themselves.
- Undefined: R Y K M B V D H S W (and lowercase) pass unchanged and count as invalid. N/n remain valid in both builds.

Test Plan:
- Reset then single beat, LANES=4, in_data="ACGT" (lane0='A'), in_rev=0, out_ready=1 -> next cycle out_data="TGCA", out_valid 1 cycle; base_count=4, invalid_count=0.
- Same beat with in_rev=1 -> out lane0..3 = 'A','C','G','T' (reverse-complement of ACGT is ACGT).
- Continuous in_valid, 16 beats, out_ready=1 -> 16 outputs on consecutive cycles; in_ready stays 1; in_last on beat 16 appears on out_last of output 16.
- out_ready held 0 while 3 beats are offered -> 2 accepted (main+skid), in_ready=0 from the cycle after the 2nd accept; release out_ready -> beats emerge in order, then the 3rd is accepted.
- in_data="AXgr", IUPAC undefined -> out "TXcr", invalid_count=2. IUPAC defined -> out "TXcy", invalid_count=1.
- stat_clear asserted on an accept cycle with base_count=12 -> counters read 0 the next cycle; reset asserted while in state SKID -> out_valid=0, in_ready=1 immediately.
